// File: rtl/hold_rr_arbiter_if.sv
// Request/grant bundle between a set of requesters and the hold_rr_arbiter.
// The requester side is the master: it drives requests and observes the grant.
interface hold_rr_arbiter_if #(
    parameter int Count = 4
);
    localparam int IdxW = $clog2(Count);

    logic [Count-1:0] requests_i;
    logic [Count-1:0] grant_o;
    logic             grant_valid_o;
    logic [IdxW-1:0]  grant_idx_o;

    modport master (
        output requests_i,
        input  grant_o,
        input  grant_valid_o,
        input  grant_idx_o
    );

    modport slave (
        input  requests_i,
        output grant_o,
        output grant_valid_o,
        output grant_idx_o
    );
endinterface

// File: rtl/hold_rr_arbiter.sv
// N-way arbiter with sticky grants. Selection is fixed priority (lowest index
// wins) or round-robin from a rotating start pointer. An optional hold limit
// forces a holder to step aside once it has kept the grant for MaxHold
// consecutive cycles while someone else is waiting. The grant is a
// combinational function of the live requests and the registered state, so a
// requester is granted in the same cycle it raises its request.
module hold_rr_arbiter #(
    parameter int Count      = 4,
    parameter bit RoundRobin = 1'b0,
    parameter int MaxHold    = 0
) (
    input logic              clk_i,
    input logic              rst_ni,
    hold_rr_arbiter_if.slave arb
);

    localparam int IdxW  = $clog2(Count);
    localparam int HoldW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;

    localparam logic [HoldW-1:0] HoldLimit = HoldW'(MaxHold);
    localparam logic [HoldW-1:0] HoldSat   = '1;
    localparam logic [IdxW-1:0]  LastIdx   = IdxW'(Count - 1);

    // First set bit of cand at or after start, wrapping past Count-1 to 0.
    function automatic logic [IdxW-1:0] rotate_pick(
        input logic [Count-1:0] cand,
        input logic [IdxW-1:0]  start
    );
        logic [IdxW-1:0] idx;
        logic            found;
        int              j;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < Count; i++) begin
            j = int'(start) + i;
            if (j >= Count) j = j - Count;
            if (!found && cand[j]) begin
                idx   = IdxW'(j);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Binary index of a one-hot (or zero) vector.
    function automatic logic [IdxW-1:0] onehot_idx(input logic [Count-1:0] vec);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int i = 0; i < Count; i++) begin
            if (vec[i]) idx = idx | IdxW'(i);
        end
        return idx;
    endfunction

    logic [Count-1:0] grant_q;
    logic [IdxW-1:0]  ptr_q;
    logic [HoldW-1:0] hold_q;

    logic [Count-1:0] others;
    logic [Count-1:0] cand;
    logic             expired;
    logic             keep;
    logic [IdxW-1:0]  start;
    logic [IdxW-1:0]  win_idx;
    logic [Count-1:0] grant_d;
    logic             new_grant;

    // Decide this cycle's grant: keep the holder unless it has expired,
    // otherwise arbitrate (excluding an expired holder for this one round).
    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        grant_d   = '0;
        others    = arb.requests_i & ~grant_q;
        expired   = (MaxHold != 0) && (hold_q >= HoldLimit) && (|others);
        keep      = (|(arb.requests_i & grant_q)) && !expired;
        cand      = expired ? others : arb.requests_i;
        start     = RoundRobin ? ptr_q : '0;
        win_idx   = rotate_pick(cand, start);
        if (keep) begin
            grant_d = grant_q;
        end else if (|cand) begin
            grant_d[win_idx] = 1'b1;
        end
        new_grant = (|grant_d) && (grant_d != grant_q);
    end

    // Outputs are held at zero while reset is asserted, independent of requests.
    assign arb.grant_o       = rst_ni ? grant_d : '0;
    assign arb.grant_valid_o = rst_ni ? (|grant_d) : 1'b0;
    assign arb.grant_idx_o   = rst_ni ? onehot_idx(grant_d) : '0;

    // Register the grant, count consecutive hold cycles and advance the RR pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            grant_q <= grant_d;
            if ((grant_d == grant_q) && (|grant_d)) begin
                hold_q <= (hold_q == HoldSat) ? hold_q : hold_q + 1'b1;
            end else if (|grant_d) begin
                hold_q <= HoldW'(1);
            end else begin
                hold_q <= '0;
            end
            if (RoundRobin && new_grant) begin
                ptr_q <= (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hold_rr_arbiter.sv
// Self-checking bench for hold_rr_arbiter. Four instances with different
// configurations share clock and reset; each is compared every cycle against
// a behavioural model that tracks the holder by index, a hold counter and a
// round-robin start position.
module tb_hold_rr_arbiter;

    localparam int NDut = 4;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    // Instance configurations: a fixed/4, b rr/4, c fixed/4 hold 3, d rr/3.
    int cfg_n   [NDut] = '{4, 4, 4, 3};
    int cfg_rr  [NDut] = '{0, 1, 0, 1};
    int cfg_max [NDut] = '{0, 0, 3, 0};

    logic [3:0] req  [NDut];
    logic [3:0] gnt  [NDut];
    logic       vld  [NDut];
    logic [1:0] gidx [NDut];

    hold_rr_arbiter_if #(.Count(4)) if_a ();
    hold_rr_arbiter_if #(.Count(4)) if_b ();
    hold_rr_arbiter_if #(.Count(4)) if_c ();
    hold_rr_arbiter_if #(.Count(3)) if_d ();

    hold_rr_arbiter #(.Count(4), .RoundRobin(1'b0), .MaxHold(0)) u_a (.clk_i(clk_i), .rst_ni(rst_ni), .arb(if_a));
    hold_rr_arbiter #(.Count(4), .RoundRobin(1'b1), .MaxHold(0)) u_b (.clk_i(clk_i), .rst_ni(rst_ni), .arb(if_b));
    hold_rr_arbiter #(.Count(4), .RoundRobin(1'b0), .MaxHold(3)) u_c (.clk_i(clk_i), .rst_ni(rst_ni), .arb(if_c));
    hold_rr_arbiter #(.Count(3), .RoundRobin(1'b1), .MaxHold(0)) u_d (.clk_i(clk_i), .rst_ni(rst_ni), .arb(if_d));

    assign if_a.requests_i = req[0];
    assign if_b.requests_i = req[1];
    assign if_c.requests_i = req[2];
    assign if_d.requests_i = req[3][2:0];

    assign gnt[0] = if_a.grant_o;
    assign gnt[1] = if_b.grant_o;
    assign gnt[2] = if_c.grant_o;
    assign gnt[3] = {1'b0, if_d.grant_o};
    assign vld[0] = if_a.grant_valid_o;
    assign vld[1] = if_b.grant_valid_o;
    assign vld[2] = if_c.grant_valid_o;
    assign vld[3] = if_d.grant_valid_o;
    assign gidx[0] = if_a.grant_idx_o;
    assign gidx[1] = if_b.grant_idx_o;
    assign gidx[2] = if_c.grant_idx_o;
    assign gidx[3] = if_d.grant_idx_o;

    // Model state: holder index (-1 = none), consecutive hold cycles, RR start.
    int m_holder [NDut];
    int m_cnt    [NDut];
    int m_ptr    [NDut];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] dut_mask(input int d);
        return 4'((1 << cfg_n[d]) - 1);
    endfunction

    // Winner index for the current requests, or -1 when nobody is granted.
    function automatic int model_pick(input int d, input logic [3:0] r);
        int  n, h, start, i;
        bit  other, expired;
        n     = cfg_n[d];
        h     = m_holder[d];
        other = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (r[k] && k != h) other = 1'b1;
        end
        expired = (cfg_max[d] != 0) && (m_cnt[d] >= cfg_max[d]) && other;
        if (h >= 0 && r[h] && !expired) return h;
        start = (cfg_rr[d] != 0) ? m_ptr[d] : 0;
        for (int k = 0; k < n; k++) begin
            i = (start + k) % n;
            if (r[i] && !(expired && i == h)) return i;
        end
        return -1;
    endfunction

    task automatic model_advance(input int d, input int w);
        if (w >= 0 && w == m_holder[d]) begin
            if (m_cnt[d] < 1000) m_cnt[d]++;
        end else if (w >= 0) begin
            m_cnt[d] = 1;
            if (cfg_rr[d] != 0) m_ptr[d] = (w + 1) % cfg_n[d];
        end else begin
            m_cnt[d] = 0;
        end
        m_holder[d] = w;
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDut; d++) begin
            m_holder[d] = -1;
            m_cnt[d]    = 0;
            m_ptr[d]    = 0;
        end
    endtask

    task automatic set_all(input logic [3:0] v);
        for (int d = 0; d < NDut; d++) req[d] = v & dut_mask(d);
    endtask

    // Called just after a falling edge with requests already applied: compare
    // every instance against the model, then step the model across the rising edge.
    task automatic cycle();
        int         w [NDut];
        logic [3:0] ev;
        #1;
        for (int d = 0; d < NDut; d++) begin
            w[d] = model_pick(d, req[d] & dut_mask(d));
            ev   = (w[d] >= 0) ? 4'(1 << w[d]) : 4'b0000;
            check($sformatf("dut%0d_grant", d), 32'(gnt[d]), 32'(ev));
            check($sformatf("dut%0d_valid", d), 32'(vld[d]), 32'(w[d] >= 0));
            check($sformatf("dut%0d_idx", d), 32'(gidx[d]), (w[d] >= 0) ? 32'(w[d]) : 32'd0);
        end
        @(posedge clk_i);
        for (int d = 0; d < NDut; d++) model_advance(d, w[d]);
        @(negedge clk_i);
    endtask

    // Reset with every requester asserted; outputs must stay at zero.
    task automatic do_reset();
        rst_ni = 1'b0;
        set_all(4'b1111);
        #1;
        for (int d = 0; d < NDut; d++) begin
            check($sformatf("rst_grant%0d", d), 32'(gnt[d]), 32'd0);
            check($sformatf("rst_valid%0d", d), 32'(vld[d]), 32'd0);
            check($sformatf("rst_idx%0d", d), 32'(gidx[d]), 32'd0);
        end
        @(negedge clk_i);
        model_reset();
        set_all(4'b0000);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [3:0] rr_req [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] mh_exp [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic [31:0] flip;

        model_reset();
        do_reset();

        // Idle: nobody requesting.
        set_all(4'b0000);
        #1;
        check("idle_grant", 32'(gnt[0]), 32'd0);
        check("idle_valid", 32'(vld[0]), 32'd0);
        check("idle_idx", 32'(gidx[0]), 32'd0);
        cycle();

        // Fixed priority with sticky hold and same-cycle handover.
        do_reset();
        set_all(4'b0110); #1; check("fix_first", 32'(gnt[0]), 32'(4'b0010)); cycle();
        set_all(4'b0111); #1; check("fix_hold", 32'(gnt[0]), 32'(4'b0010)); cycle();
        set_all(4'b0101); #1; check("fix_handover", 32'(gnt[0]), 32'(4'b0001)); cycle();

        // Round-robin rotation, each grantee dropping once granted.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_all(rr_req[i]);
            #1;
            check($sformatf("rr_seq%0d", i), 32'(gnt[1]), 32'(rr_exp[i]));
            cycle();
        end

        // Hold limit: forced release, return of the masked holder, saturation.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_all(4'b0011);
            #1;
            check($sformatf("mh_seq%0d", i), 32'(gnt[2]), 32'(mh_exp[i]));
            cycle();
        end
        for (int i = 0; i < 13; i++) begin
            set_all(4'b0001);
            #1;
            check($sformatf("mh_alone%0d", i), 32'(gnt[2]), 32'(4'b0001));
            cycle();
        end
        set_all(4'b0011); #1; check("mh_sat_expire", 32'(gnt[2]), 32'(4'b0010)); cycle();

        // Count=3 round-robin: pointer wraps from the last index to 0.
        do_reset();
        set_all(4'b0100); #1;
        check("c3_last_grant", 32'(gnt[3]), 32'(4'b0100));
        check("c3_last_idx", 32'(gidx[3]), 32'd2);
        cycle();
        set_all(4'b0011); #1;
        check("c3_wrap_grant", 32'(gnt[3]), 32'(4'b0001));
        check("c3_wrap_idx", 32'(gidx[3]), 32'd0);
        cycle();

        // Reset asserted while a grant is held; pointer returns to 0.
        do_reset();
        set_all(4'b0100); #1; check("mid_pre", 32'(gnt[1]), 32'(4'b0100)); cycle();
        #2 rst_ni = 1'b0;
        #1;
        check("mid_grant", 32'(gnt[1]), 32'd0);
        check("mid_valid", 32'(vld[1]), 32'd0);
        check("mid_idx", 32'(gidx[1]), 32'd0);
        @(negedge clk_i);
        model_reset();
        set_all(4'b1100);
        rst_ni = 1'b1;
        #1;
        check("mid_post", 32'(gnt[1]), 32'(4'b0100));
        cycle();

        // Random traffic: requests toggle sparsely so grants get held and contended.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < NDut; d++) begin
                flip   = $urandom & $urandom & $urandom;
                req[d] = (req[d] ^ flip[3:0]) & dut_mask(d);
                if ($urandom_range(0, 49) == 0) req[d] = 4'b0000;
            end
            cycle();
            if (n % 200 == 199) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
